// File: rtl/mini_calc_pkg.sv
// Shared definitions for mini_calc_seq: default opcodes, FSM state encoding and iteration-counter sizing.
// The optional divider is selected by MINI_CALC_SEQ_DIV_EN in the modules that import this package.
package mini_calc_pkg;

  localparam int DEF_INPUT_BIT_WIDTH = 8;
  localparam int DEF_INSTR_BIT_WIDTH = 4;

  localparam logic [3:0] DEF_CODE_INSTR_NOP     = 4'b1111;
  localparam logic [3:0] DEF_CODE_INSTR_ADD_SUB = 4'b0111;
  localparam logic [3:0] DEF_CODE_INSTR_MIN_MAX = 4'b1011;
  localparam logic [3:0] DEF_CODE_INSTR_MUL     = 4'b1101;
  localparam logic [3:0] DEF_CODE_INSTR_DIV     = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter must be able to hold the operand width itself.
  function automatic int iter_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEF_ITER_CNT_W = iter_cnt_width(DEF_INPUT_BIT_WIDTH);

endpackage

// File: rtl/mini_calc_seq_divider.sv
// Iterative restoring divider, one quotient bit per clock; the MSB is resolved on the Start edge.
// Only instantiated when MINI_CALC_SEQ_DIV_EN is defined. A zero divisor yields all-ones / Dividend.
module mini_calc_seq_divider
  import mini_calc_pkg::*;
#(
  parameter int WIDTH = DEF_INPUT_BIT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divider,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = iter_cnt_width(WIDTH);

  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_den;

  logic             w_load;
  logic [WIDTH-1:0] w_rem_in;
  logic [WIDTH-1:0] w_quo_in;
  logic [WIDTH-1:0] w_den;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;

  // On the load edge the step works directly on the incoming operands.
  assign w_load     = Start && !r_busy;
  assign w_rem_in   = w_load ? '0 : r_rem;
  assign w_quo_in   = w_load ? Dividend : r_quo;
  assign w_den      = w_load ? Divider : r_den;
  assign w_shift    = {w_rem_in, w_quo_in[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, w_den});
  assign w_trial    = w_shift[WIDTH-1:0] - w_den;
  assign w_rem_next = w_ge ? w_trial : w_shift[WIDTH-1:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_den  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_busy <= 1'b1;
        r_cnt  <= CW'(1);
        r_den  <= Divider;
        r_dbz  <= (Divider == '0);
        r_rem  <= w_rem_next;
        r_quo  <= {w_quo_in[WIDTH-2:0], w_ge};
      end else if (r_busy) begin
        r_rem <= w_rem_next;
        r_quo <= {w_quo_in[WIDTH-2:0], w_ge};
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign Quotient  = r_quo;
  assign Remainder = r_rem;
  assign Done      = r_done;
  assign DivByZero = r_dbz;

endmodule

// File: rtl/mini_calc_seq.sv
// Sequential mini calculator: single-cycle add/sub, min/max, nop, pass-through; iterative multiply,
// and iterative divide when MINI_CALC_SEQ_DIV_EN is defined (otherwise DIV returns Error at latency 1).
module mini_calc_seq
  import mini_calc_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH = DEF_INPUT_BIT_WIDTH,
  parameter int INSTR_BIT_WIDTH = DEF_INSTR_BIT_WIDTH,
  parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_NOP     = INSTR_BIT_WIDTH'(DEF_CODE_INSTR_NOP),
  parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_ADD_SUB = INSTR_BIT_WIDTH'(DEF_CODE_INSTR_ADD_SUB),
  parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_MIN_MAX = INSTR_BIT_WIDTH'(DEF_CODE_INSTR_MIN_MAX),
  parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_MUL     = INSTR_BIT_WIDTH'(DEF_CODE_INSTR_MUL),
  parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_DIV     = INSTR_BIT_WIDTH'(DEF_CODE_INSTR_DIV)
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [INSTR_BIT_WIDTH-1:0] Instruction,
  input  logic [INPUT_BIT_WIDTH-1:0] InputA,
  input  logic [INPUT_BIT_WIDTH-1:0] InputB,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [INPUT_BIT_WIDTH-1:0] OutputA,
  output logic [INPUT_BIT_WIDTH-1:0] OutputB,
  output logic                       Error
);

  localparam int W  = INPUT_BIT_WIDTH;
  localparam int CW = iter_cnt_width(W);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_mul_a;
  logic [2*W-1:0]  r_prod;
  logic            r_out_valid;
  logic [W-1:0]    r_out_a;
  logic [W-1:0]    r_out_b;
  logic            r_error;

  logic            w_accept;
  logic            w_to_exec;
  logic [W-1:0]    w_imm_a;
  logic [W-1:0]    w_imm_b;
  logic            w_imm_err;
  logic [W:0]      w_mul_sum;
  logic [2*W-1:0]  w_prod_next;
  logic            w_last_iter;

  assign InReady  = (r_state == IDLE);
  assign w_accept = InValid && InReady;

  // Shift-add: low half of r_prod holds the remaining multiplier bits, high half the partial sum.
  assign w_mul_sum   = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_mul_a} : {(W+1){1'b0}});
  assign w_prod_next = {w_mul_sum, r_prod[W-1:1]};
  assign w_last_iter = (r_cnt == CW'(W - 1));

`ifdef MINI_CALC_SEQ_DIV_EN
  logic         r_op_div;
  logic         w_is_div;
  logic         w_div_start;
  logic         w_div_done;
  logic         w_div_dbz;
  logic [W-1:0] w_quo;
  logic [W-1:0] w_rem;

  assign w_div_start = w_accept && w_is_div;

  mini_calc_seq_divider #(
    .WIDTH(W)
  ) u_divider (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (w_div_start),
    .Dividend (InputA),
    .Divider  (InputB),
    .Quotient (w_quo),
    .Remainder(w_rem),
    .Done     (w_div_done),
    .DivByZero(w_div_dbz)
  );
`endif

  always_comb begin
    w_imm_a   = InputA;
    w_imm_b   = InputB;
    w_imm_err = 1'b0;
    w_to_exec = 1'b0;
`ifdef MINI_CALC_SEQ_DIV_EN
    w_is_div  = 1'b0;
`endif
    if (Instruction == CODE_INSTR_NOP) begin
      w_imm_a = '0;
      w_imm_b = '0;
    end else if (Instruction == CODE_INSTR_ADD_SUB) begin
      w_imm_a = InputA + InputB;
      w_imm_b = InputA - InputB;
    end else if (Instruction == CODE_INSTR_MIN_MAX) begin
      if (InputA <= InputB) begin
        w_imm_a = InputA;
        w_imm_b = InputB;
      end else begin
        w_imm_a = InputB;
        w_imm_b = InputA;
      end
    end else if (Instruction == CODE_INSTR_MUL) begin
      w_to_exec = 1'b1;
    end else if (Instruction == CODE_INSTR_DIV) begin
`ifdef MINI_CALC_SEQ_DIV_EN
      w_to_exec = 1'b1;
      w_is_div  = 1'b1;
`else
      w_imm_a   = '0;
      w_imm_b   = '0;
      w_imm_err = 1'b1;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mul_a     <= '0;
      r_prod      <= '0;
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_error     <= 1'b0;
`ifdef MINI_CALC_SEQ_DIV_EN
      r_op_div    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mul_a <= InputA;
            r_prod  <= {{W{1'b0}}, InputB};
            r_cnt   <= '0;
`ifdef MINI_CALC_SEQ_DIV_EN
            r_op_div <= w_is_div;
`endif
            if (w_to_exec) begin
              r_state <= EXEC;
            end else begin
              r_out_a     <= w_imm_a;
              r_out_b     <= w_imm_b;
              r_error     <= w_imm_err;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        EXEC: begin
`ifdef MINI_CALC_SEQ_DIV_EN
          if (r_op_div) begin
            if (w_div_done) begin
              r_out_a     <= w_quo;
              r_out_b     <= w_rem;
              r_error     <= w_div_dbz;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end else
`endif
          begin
            r_prod <= w_prod_next;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last_iter) begin
              r_out_a     <= w_prod_next[W-1:0];
              r_out_b     <= w_prod_next[2*W-1:W];
              r_error     <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        DONE: begin
          if (OutReady) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign OutValid = r_out_valid;
  assign OutputA  = r_out_a;
  assign OutputB  = r_out_b;
  assign Error    = r_error;

endmodule

// File: tb/tb_mini_calc_seq.sv
// Scoreboard bench for mini_calc_seq at W=8: expected results queued at acceptance, compared at handshake.
// DIV expectations follow MINI_CALC_SEQ_DIV_EN when the build defines it.
`timescale 1ns/1ps
module tb_mini_calc_seq;

  localparam logic [3:0] OP_NOP   = 4'b1111;
  localparam logic [3:0] OP_ADD   = 4'b0111;
  localparam logic [3:0] OP_MM    = 4'b1011;
  localparam logic [3:0] OP_MUL   = 4'b1101;
  localparam logic [3:0] OP_DIV   = 4'b1110;
  localparam logic [3:0] OP_UNDEF = 4'b0011;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       InValid;
  logic       InReady;
  logic [3:0] Instruction;
  logic [7:0] InputA;
  logic [7:0] InputB;
  logic       OutValid;
  logic       OutReady;
  logic [7:0] OutputA;
  logic [7:0] OutputB;
  logic       Error;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       eerr;
    int         lat;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_assert = 0;
  int         n_fail = 0;
  int         n_results = 0;
  int         n_sent = 0;
  logic [3:0] b2b_ops [6];

  mini_calc_seq dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .InValid    (InValid),
    .InReady    (InReady),
    .Instruction(Instruction),
    .InputA     (InputA),
    .InputB     (InputB),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutputA    (OutputA),
    .OutputB    (OutputB),
    .Error      (Error)
  );

  always #5 Clk = ~Clk;

  initial begin
    forever begin
      @(posedge Clk);
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t        e;
    logic [15:0] p;
    e.op = op; e.a = a; e.b = b; e.eerr = 1'b0; e.lat = 1; e.acc = 0;
    case (op)
      OP_NOP: begin e.ea = 8'd0; e.eb = 8'd0; end
      OP_ADD: begin e.ea = a + b; e.eb = a - b; end
      OP_MM:  begin e.ea = (a < b) ? a : b; e.eb = (a < b) ? b : a; end
      OP_MUL: begin
        p = 16'(a) * 16'(b);
        e.ea = p[7:0]; e.eb = p[15:8]; e.lat = 9;
      end
      OP_DIV: begin
`ifdef MINI_CALC_SEQ_DIV_EN
        e.lat = 9;
        if (b == 8'd0) begin e.ea = 8'hFF; e.eb = a; e.eerr = 1'b1; end
        else begin e.ea = a / b; e.eb = a % b; end
`else
        e.ea = 8'd0; e.eb = 8'd0; e.eerr = 1'b1;
`endif
      end
      default: begin e.ea = a; e.eb = b; end
    endcase
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   n = 0;
    Instruction = op; InputA = a; InputB = b; InValid = 1'b1;
    do begin
      @(negedge Clk);
      n++;
    end while (!InReady && n < 200);
    check("accept_ready", {31'b0, InReady}, 32'd1);
    e = model(op, a, b);
    e.acc = cyc;
    sb.push_back(e);
    n_sent++;
    @(posedge Clk); #1;
    InValid = 1'b0;
    Instruction = 4'($urandom);
    InputA = 8'($urandom);
    InputB = 8'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("drain_empty", sb.size(), 32'd0);
    @(posedge Clk); #1;
  endtask

  // Output monitor: latency on first OutValid, values on each handshake.
  initial begin
    exp_t e;
    logic prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        prev_ov = 1'b0;
      end else begin
        if (OutValid && !prev_ov) begin
          n_assert++;
          assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL unexpected_result observed=OutValid=1 expected=no pending request");
          end
          if (sb.size() > 0) check("latency", cyc - sb[0].acc, sb[0].lat);
        end
        if (OutValid && OutReady && sb.size() > 0) begin
          e = sb.pop_front();
          n_results++;
          $display("result op=%b A=%0d B=%0d -> OutputA=%0d OutputB=%0d Error=%0b (expect %0d %0d %0b)",
                   e.op, e.a, e.b, OutputA, OutputB, Error, e.ea, e.eb, e.eerr);
          check("outputA", OutputA, e.ea);
          check("outputB", OutputB, e.eb);
          check("error", Error, e.eerr);
        end
        prev_ov = OutValid;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b2b_ops[0] = OP_ADD; b2b_ops[1] = OP_MM;  b2b_ops[2] = OP_MUL;
    b2b_ops[3] = OP_DIV; b2b_ops[4] = OP_NOP; b2b_ops[5] = OP_UNDEF;
    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    Instruction = 4'd0; InputA = 8'd0; InputB = 8'd0;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_outvalid", OutValid, 32'd0);
    check("rst_outputA", OutputA, 32'd0);
    check("rst_outputB", OutputB, 32'd0);
    check("rst_error", Error, 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("inready_after_reset", InReady, 32'd1);
    @(posedge Clk); #1;

    OutReady = 1'b1;
    send(OP_ADD, 8'd200, 8'd100);
    wait_drain();

    send(OP_MUL, 8'd255, 8'd255);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      check("mul_busy_inready", InReady, 32'd0);
      check("mul_busy_outvalid", OutValid, 32'd0);
    end
    wait_drain();

    send(OP_DIV, 8'd100, 8'd7);
    send(OP_DIV, 8'd9, 8'd0);
    send(OP_ADD, 8'd255, 8'd1);
    send(OP_MM, 8'd7, 8'd7);
    send(OP_NOP, 8'd5, 8'd6);
    send(OP_UNDEF, 8'd77, 8'd33);
    send(OP_MUL, 8'd13, 8'd11);
    send(OP_MM, 8'd200, 8'd10);
    wait_drain();

    // Result held while the consumer stalls; requests meanwhile must be ignored.
    OutReady = 1'b0;
    send(OP_MM, 8'd3, 8'd250);
    for (int i = 0; i < 5; i++) begin
      InValid = i[0]; Instruction = OP_ADD; InputA = 8'(i); InputB = 8'd1;
      @(negedge Clk);
      check("hold_outvalid", OutValid, 32'd1);
      check("hold_outputA", OutputA, 32'd3);
      check("hold_outputB", OutputB, 32'd250);
      check("hold_inready", InReady, 32'd0);
      @(posedge Clk); #1;
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    @(negedge Clk);
    @(posedge Clk); #1;
    @(negedge Clk);
    check("release_inready", InReady, 32'd1);
    check("release_outvalid", OutValid, 32'd0);
    @(posedge Clk); #1;

    // Abort a multiply in its 4th EXEC cycle.
    send(OP_MUL, 8'd77, 8'd3);
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    sb.delete();
    n_sent--;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("abort_inready", InReady, 32'd1);
    check("abort_outvalid", OutValid, 32'd0);
    check("abort_outputA", OutputA, 32'd0);
    check("abort_outputB", OutputB, 32'd0);
    check("abort_error", Error, 32'd0);
    repeat (15) @(posedge Clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      send(b2b_ops[i % 6], 8'($urandom), (i == 3) ? 8'd0 : 8'($urandom_range(0, 255)));
    end
    wait_drain();
    check("result_count", n_results, n_sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
